stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control sequencer for the 3-digit BCD stopwatch datapath: debounces three raw active-low buttons (Start, Stop, Lap) and runs the Idle/Run/Pause/Lap/Done state machine.
- Generates the datapath's count enable, 1-cycle tick strobe, clear pulse, lap-capture pulse and display-select.
- Sits between the board pushbuttons and the digit counter/FND datapath. The datapath only counts on o_fTick and never keeps its own state machine.

Parameters:
- TICK_DIV, 10_000_000: clocks per count tick (0.1 s at 100 MHz); must be >= 2.
- DB_CNT, 1_000_000: consecutive stable cycles needed to accept a new button level; must be >= 1.
- STOP_ON_OVF, 1: 1 = enter DONE at full scale (999); 0 = let the datapath wrap to 000 and keep running.

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  asynchronous, active-low reset
- i_nStart  in  1  raw Start/Pause button, active-low, asynchronous to i_Clk
- i_nStop  in  1  raw Stop/Clear button, active-low, asynchronous
- i_nLap  in  1  raw Lap button, active-low, asynchronous
- i_fOvf  in  1  from datapath: count is at full scale (all digits 9)
- o_fRun  out  1  count enable; high in RUN and LAP
- o_fTick  out  1  1-cycle increment strobe to the datapath
- o_fClr  out  1  1-cycle synchronous clear to the datapath
- o_fLapLd  out  1  1-cycle strobe: datapath copies live count into its lap register
- o_fShowLap  out  1  display mux select; 1 = show lap register, 0 = show live count
- o_State  out  3  current state: IDLE=0, RUN=1, PAUSE=2, LAP=3, DONE=4

Behaviour:
- Reset (i_Rst=0, async): state=IDLE, tick counter=0, all pulse outputs=0. Sync flops and debounced levels reset to 1 (released), so releasing reset while a button is held produces no press.
- Each button input: 2-flop synchronizer, then debouncer. Counter clears while synced==debounced and increments while they differ; when it reaches DB_CNT-1 while still differing, debounced<=synced and the counter clears. A glitch shorter than DB_CNT cycles causes no change.
- Press event: debounced level goes 1->0. Release generates no event. A held button generates exactly one event.
- Latency: state register updates on the (DB_CNT+3)th rising edge, counting the first edge that samples the pin low.
- Simultaneous events in one cycle: priority Stop > Start > Lap. Lower-priority events in that cycle are discarded.
- IDLE: Start -> RUN. Stop and Lap are ignored.
- RUN: Stop -> IDLE. Start -> PAUSE. Lap -> LAP.
- LAP: Stop -> IDLE. Start -> PAUSE. Lap -> RUN (display returns to live).
- PAUSE: Stop -> IDLE. Start -> RUN. Lap is ignored.
- DONE: Stop -> IDLE. Start and Lap are ignored.
- Overflow, RUN/LAP with STOP_ON_OVF=1: if the tick condition and i_fOvf are both true in a cycle, o_fTick is suppressed that cycle and next state = DONE. The count stays at 999.
- Overflow during a button event: a Stop event in the same cycle wins (-> IDLE). Start and Lap events in that cycle lose to the overflow.
- Tick counter: counts 0..TICK_DIV-1 and wraps, advancing only in RUN/LAP.
  - Holds its value in PAUSE, so a resumed interval is not restarted.
  - Forced to 0 in IDLE and DONE.
- o_fTick = (tick counter == TICK_DIV-1) && state in {RUN, LAP} && !(STOP_ON_OVF && i_fOvf). Combinational from registered values.
- o_fRun and o_fShowLap are registered, decoded from next state (they change with o_State).
  - o_fRun = RUN or LAP.
  - o_fShowLap = LAP, or PAUSE entered from LAP. It stays 1 through that PAUSE and clears on the next transition out of PAUSE.
- o_fClr: registered. High for exactly the one cycle in which o_State first reads IDLE after a Stop event. Not asserted at reset; the datapath resets itself.
- o_fLapLd: registered. High for exactly the one cycle in which o_State first reads LAP after RUN->LAP.
- Reset mid-operation: all outputs drop to reset values immediately; no pulse is emitted on reset release.

Test Plan:
(All with TICK_DIV=4, DB_CNT=3.)
- Debounce: pull i_nStart low for 2 cycles then high -> o_State stays 0. Hold it low 10 cycles -> o_State=1 exactly at edge 6 after the first low sample; a single transition only.
- Run timing: Start press, hold RUN 20 cycles -> o_fTick pulses every 4th cycle, 5 pulses total. Start press -> PAUSE, tick counter held. Start again -> first tick arrives after the remaining count, not after a full 4.
- Lap: in RUN press Lap -> o_State=3, o_fLapLd=1 for 1 cycle, o_fShowLap=1, ticks continue. Press Lap -> o_State=1, o_fShowLap=0, no o_fLapLd.
- Stop priority: assert Start and Stop events in the same cycle from RUN -> o_State=0, o_fClr=1 for 1 cycle, tick counter 0, no PAUSE visited.
- Overflow: STOP_ON_OVF=1, RUN, hold i_fOvf=1 -> at the tick slot o_fTick=0, o_State=4, o_fRun=0. Start ignored. Stop -> IDLE with o_fClr pulse. STOP_ON_OVF=0 -> o_fTick=1 and state stays RUN.
- Async reset mid-RUN with i_nLap held low -> all outputs 0 and o_State=0 immediately. After release, no Lap event occurs until the button is released and pressed again.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounces Start/Stop/Lap and drives the BCD datapath
// with count enable, tick, clear, lap-capture and display-select strobes.
//
// state | meaning
// IDLE  | stopped, count cleared, waiting for Start
// RUN   | counting, live count displayed
// PAUSE | counting frozen, tick phase held
// LAP   | counting, frozen lap value displayed
// DONE  | full scale reached, waiting for Stop
module stopwatch_ctrl #(
    parameter int TICK_DIV    = 10_000_000,
    parameter int DB_CNT      = 1_000_000,
    parameter int STOP_ON_OVF = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_nStart,
    input  logic       i_nStop,
    input  logic       i_nLap,
    input  logic       i_fOvf,
    output logic       o_fRun,
    output logic       o_fTick,
    output logic       o_fClr,
    output logic       o_fLapLd,
    output logic       o_fShowLap,
    output logic [2:0] o_State
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_PAUSE = 3'd2;
    localparam logic [2:0] S_LAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DB_CNT + 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX   = DW'(DB_CNT - 1);

    // button index: 0 = Start, 1 = Stop, 2 = Lap
    logic [2:0]    raw_btn;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    db_lvl;
    logic [2:0]    db_q;
    logic [2:0]    armed;
    logic [DW-1:0] db_cnt [3];
    logic [1:0]    warm;
    logic          warm_done;
    logic [2:0]    press;

    logic          ev_start;
    logic          ev_stop;
    logic          ev_lap;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [TW-1:0] tick_cnt;
    logic          counting;
    logic          tick_slot;
    logic          ovf_hold;
    logic          ovf_stop;

    logic          run_q;
    logic          show_q;
    logic          show_nxt;
    logic          clr_q;
    logic          lapld_q;

    assign raw_btn   = {i_nLap, i_nStop, i_nStart};
    assign warm_done = (warm == 2'd2);

    // A button must be seen released after reset (armed) before its first
    // press counts, so a button held through reset release gives no event.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            sync1  <= '1;
            sync2  <= '1;
            db_lvl <= '1;
            db_q   <= '1;
            armed  <= '0;
            warm   <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw_btn;
            sync2 <= sync1;
            db_q  <= db_lvl;
            if (!warm_done) begin
                warm <= warm + 2'd1;
            end
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    db_lvl[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
                if (warm_done && sync2[i] && db_lvl[i]) begin
                    armed[i] <= 1'b1;
                end
            end
        end
    end

    assign press    = db_q & ~db_lvl & armed;
    assign ev_stop  = press[1];
    assign ev_start = press[0] & ~press[1];
    assign ev_lap   = press[2] & ~press[1] & ~press[0];

    assign counting  = (state == S_RUN) || (state == S_LAP);
    assign tick_slot = counting && (tick_cnt == TICK_MAX);
    assign ovf_hold  = (STOP_ON_OVF != 0) && i_fOvf;
    assign ovf_stop  = tick_slot && ovf_hold;
    assign o_fTick   = tick_slot && !ovf_hold;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ev_start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (ev_stop)        state_nxt = S_IDLE;
                else if (ovf_stop)  state_nxt = S_DONE;
                else if (ev_start)  state_nxt = S_PAUSE;
                else if (ev_lap)    state_nxt = S_LAP;
            end
            S_LAP: begin
                if (ev_stop)        state_nxt = S_IDLE;
                else if (ovf_stop)  state_nxt = S_DONE;
                else if (ev_start)  state_nxt = S_PAUSE;
                else if (ev_lap)    state_nxt = S_RUN;
            end
            S_PAUSE: begin
                if (ev_stop)        state_nxt = S_IDLE;
                else if (ev_start)  state_nxt = S_RUN;
            end
            S_DONE: begin
                if (ev_stop)        state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Lap display survives a pause taken from LAP, and only that pause.
    always_comb begin
        show_nxt = 1'b0;
        if (state_nxt == S_LAP) begin
            show_nxt = 1'b1;
        end else if (state_nxt == S_PAUSE) begin
            show_nxt = (state == S_LAP) || ((state == S_PAUSE) && show_q);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            run_q    <= 1'b0;
            show_q   <= 1'b0;
            clr_q    <= 1'b0;
            lapld_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            run_q   <= (state_nxt == S_RUN) || (state_nxt == S_LAP);
            show_q  <= show_nxt;
            clr_q   <= ev_stop && (state != S_IDLE);
            lapld_q <= (state == S_RUN) && (state_nxt == S_LAP);
            if ((state_nxt == S_IDLE) || (state_nxt == S_DONE)) begin
                tick_cnt <= '0;
            end else if (counting) begin
                tick_cnt <= (tick_cnt == TICK_MAX) ? '0 : tick_cnt + TW'(1);
            end
        end
    end

    assign o_State    = state;
    assign o_fRun     = run_q;
    assign o_fShowLap = show_q;
    assign o_fClr     = clr_q;
    assign o_fLapLd   = lapld_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DB_CNT=3; a second instance
// with STOP_ON_OVF=0 shares the stimulus to cover the wrap-around case.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       n_start;
    logic       n_stop;
    logic       n_lap;
    logic       ovf;

    logic       run, tick, clr, lapld, showlap;
    logic [2:0] st;
    logic       w_run, w_tick, w_clr, w_lapld, w_showlap;
    logic [2:0] w_st;

    int checks   = 0;
    int failures = 0;

    stopwatch_ctrl #(.TICK_DIV(4), .DB_CNT(3), .STOP_ON_OVF(1)) dut (
        .i_Clk(clk), .i_Rst(rst_n), .i_nStart(n_start), .i_nStop(n_stop),
        .i_nLap(n_lap), .i_fOvf(ovf), .o_fRun(run), .o_fTick(tick), .o_fClr(clr),
        .o_fLapLd(lapld), .o_fShowLap(showlap), .o_State(st)
    );

    stopwatch_ctrl #(.TICK_DIV(4), .DB_CNT(3), .STOP_ON_OVF(0)) dut_wrap (
        .i_Clk(clk), .i_Rst(rst_n), .i_nStart(n_start), .i_nStop(n_stop),
        .i_nLap(n_lap), .i_fOvf(ovf), .o_fRun(w_run), .o_fTick(w_tick), .o_fClr(w_clr),
        .o_fLapLd(w_lapld), .o_fShowLap(w_showlap), .o_State(w_st)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Press takes DB_CNT+3 = 6 edges to reach the state register.
    task automatic press(input logic s, input logic p, input logic l);
        if (s) n_start = 1'b0;
        if (p) n_stop  = 1'b0;
        if (l) n_lap   = 1'b0;
        step(6);
    endtask

    task automatic release_all();
        n_start = 1'b1;
        n_stop  = 1'b1;
        n_lap   = 1'b1;
        step(7);
    endtask

    task automatic test_reset();
        step(3);
        checks++;
        if ({st, run, tick, clr, lapld, showlap} !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b expected=%b", {st, run, tick, clr, lapld, showlap}, 8'd0);
        end
        rst_n = 1'b1;
        step(5);
        checks++;
        if ({st, run, clr} !== 5'd0) begin
            failures++;
            $display("FAIL reset_release got=%b expected=%b", {st, run, clr}, 5'd0);
        end
    endtask

    task automatic test_debounce();
        int bad;
        n_start = 1'b0;
        step(2);
        n_start = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (st !== 3'd0) bad++;
            step(1);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL glitch_ignored bad_cycles=%0d expected=0", bad);
        end
        n_start = 1'b0;
        step(5);
        checks++;
        if (st !== 3'd0) begin
            failures++;
            $display("FAIL press_edge5 state=%0d expected=0", st);
        end
        step(1);
        checks++;
        if (st !== 3'd1 || run !== 1'b1) begin
            failures++;
            $display("FAIL press_edge6 state=%0d run=%b expected state=1 run=1", st, run);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (st !== 3'd1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL held_single_event bad_cycles=%0d expected=0", bad);
        end
        release_all();
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (st !== 3'd0 || clr !== 1'b1 || run !== 1'b0) begin
            failures++;
            $display("FAIL stop_to_idle state=%0d clr=%b run=%b expected 0/1/0", st, clr, run);
        end
        step(1);
        checks++;
        if (clr !== 1'b0) begin
            failures++;
            $display("FAIL clr_one_cycle clr=%b expected=0", clr);
        end
        release_all();
    endtask

    task automatic test_run_timing();
        int ticks;
        int bad;
        press(1'b1, 1'b0, 1'b0);
        n_start = 1'b1;
        ticks = 0;
        bad = 0;
        for (int i = 1; i <= 20; i++) begin
            if (tick === 1'b1) begin
                ticks++;
                if (i % 4 != 0) bad++;
            end
            step(1);
        end
        checks++;
        if (ticks != 5 || bad != 0) begin
            failures++;
            $display("FAIL tick_rate ticks=%0d misplaced=%0d expected ticks=5 misplaced=0", ticks, bad);
        end
        // tick counter is 0 here; 6 more RUN edges leave it at 2 on entering PAUSE
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (st !== 3'd2 || run !== 1'b0) begin
            failures++;
            $display("FAIL pause_entry state=%0d run=%b expected state=2 run=0", st, run);
        end
        n_start = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (tick !== 1'b0 || st !== 3'd2) bad++;
            step(1);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL pause_hold bad_cycles=%0d expected=0", bad);
        end
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (st !== 3'd1 || tick !== 1'b0) begin
            failures++;
            $display("FAIL resume_entry state=%0d tick=%b expected state=1 tick=0", st, tick);
        end
        step(1);
        checks++;
        if (tick !== 1'b1) begin
            failures++;
            $display("FAIL resume_partial_tick tick=%b expected=1", tick);
        end
        n_start = 1'b1;
        step(7);
    endtask

    task automatic test_lap();
        int ticks;
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (st !== 3'd3 || lapld !== 1'b1 || showlap !== 1'b1 || run !== 1'b1) begin
            failures++;
            $display("FAIL lap_entry state=%0d lapld=%b show=%b run=%b expected 3/1/1/1", st, lapld, showlap, run);
        end
        step(1);
        checks++;
        if (lapld !== 1'b0 || st !== 3'd3) begin
            failures++;
            $display("FAIL lapld_one_cycle lapld=%b state=%0d expected 0/3", lapld, st);
        end
        n_lap = 1'b1;
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            if (tick === 1'b1) ticks++;
            step(1);
        end
        checks++;
        if (ticks != 2) begin
            failures++;
            $display("FAIL lap_ticks ticks=%0d expected=2", ticks);
        end
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (st !== 3'd1 || showlap !== 1'b0 || lapld !== 1'b0) begin
            failures++;
            $display("FAIL lap_return state=%0d show=%b lapld=%b expected 1/0/0", st, showlap, lapld);
        end
        release_all();
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (st !== 3'd3 || lapld !== 1'b1) begin
            failures++;
            $display("FAIL lap_again state=%0d lapld=%b expected 3/1", st, lapld);
        end
        release_all();
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (st !== 3'd2 || showlap !== 1'b1 || run !== 1'b0) begin
            failures++;
            $display("FAIL pause_from_lap state=%0d show=%b run=%b expected 2/1/0", st, showlap, run);
        end
        release_all();
        checks++;
        if (showlap !== 1'b1) begin
            failures++;
            $display("FAIL show_held_in_pause show=%b expected=1", showlap);
        end
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (st !== 3'd1 || showlap !== 1'b0 || run !== 1'b1) begin
            failures++;
            $display("FAIL resume_from_lap_pause state=%0d show=%b run=%b expected 1/0/1", st, showlap, run);
        end
        release_all();
    endtask

    task automatic test_stop_priority();
        int visited;
        n_start = 1'b0;
        n_stop  = 1'b0;
        visited = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (st === 3'd2) visited++;
        end
        checks++;
        if (st !== 3'd0 || clr !== 1'b1 || visited != 0) begin
            failures++;
            $display("FAIL stop_priority state=%0d clr=%b pause_cycles=%0d expected 0/1/0", st, clr, visited);
        end
        step(1);
        checks++;
        if (clr !== 1'b0) begin
            failures++;
            $display("FAIL stop_priority_clr_width clr=%b expected=0", clr);
        end
        release_all();
    endtask

    task automatic test_overflow();
        int bad;
        press(1'b1, 1'b0, 1'b0);
        n_start = 1'b1;
        ovf = 1'b1;
        bad = 0;
        for (int i = 1; i <= 3; i++) begin
            if (tick !== 1'b0 || w_tick !== 1'b0 || st !== 3'd1) bad++;
            step(1);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL ovf_pre_slot bad_cycles=%0d expected=0", bad);
        end
        checks++;
        if (tick !== 1'b0 || w_tick !== 1'b1 || st !== 3'd1) begin
            failures++;
            $display("FAIL ovf_slot tick=%b wrap_tick=%b state=%0d expected 0/1/1", tick, w_tick, st);
        end
        step(1);
        checks++;
        if (st !== 3'd4 || run !== 1'b0) begin
            failures++;
            $display("FAIL ovf_done state=%0d run=%b expected 4/0", st, run);
        end
        checks++;
        if (w_st !== 3'd1 || w_run !== 1'b1) begin
            failures++;
            $display("FAIL ovf_wrap_keeps_running state=%0d run=%b expected 1/1", w_st, w_run);
        end
        step(7);
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (st !== 3'd4 || tick !== 1'b0) begin
            failures++;
            $display("FAIL done_ignores_start state=%0d tick=%b expected 4/0", st, tick);
        end
        release_all();
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (st !== 3'd0 || clr !== 1'b1) begin
            failures++;
            $display("FAIL done_stop state=%0d clr=%b expected 0/1", st, clr);
        end
        ovf = 1'b0;
        release_all();
    endtask

    task automatic test_async_reset();
        int bad;
        press(1'b1, 1'b0, 1'b0);
        release_all();
        n_lap = 1'b0;
        step(2);
        checks++;
        if (st !== 3'd1 || run !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_run state=%0d run=%b expected 1/1", st, run);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({st, run, tick, clr, lapld, showlap} !== 8'd0) begin
            failures++;
            $display("FAIL async_reset got=%b expected=%b", {st, run, tick, clr, lapld, showlap}, 8'd0);
        end
        @(posedge clk);
        #1;
        step(2);
        rst_n = 1'b1;
        step(4);
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (st !== 3'd1 || clr !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_start state=%0d clr=%b expected 1/0", st, clr);
        end
        n_start = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (st !== 3'd1 || lapld !== 1'b0) bad++;
            step(1);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL held_lap_no_event bad_cycles=%0d expected=0", bad);
        end
        n_lap = 1'b1;
        step(8);
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (st !== 3'd3 || lapld !== 1'b1) begin
            failures++;
            $display("FAIL lap_after_rearm state=%0d lapld=%b expected 3/1", st, lapld);
        end
        release_all();
    endtask

    initial begin
        rst_n   = 1'b0;
        n_start = 1'b1;
        n_stop  = 1'b1;
        n_lap   = 1'b1;
        ovf     = 1'b0;
        test_reset();
        test_debounce();
        test_run_timing();
        test_lap();
        test_stop_priority();
        test_overflow();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
